// File: rtl/ahb_master_datapath.sv
// AHB-Lite master datapath: burst address generation, write FIFO feeding HWDATA, read FIFO
// capturing HRDATA. Optional 1 KB boundary checker enabled by macro AHB_DP_BOUNDARY_CHECK_EN.
module ahb_master_datapath #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WDEPTH = 8,
  parameter int RDEPTH = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    load,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [2:0]              burst,
  input  logic [2:0]              size,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic                    HREADY,
  input  logic [DATA_W-1:0]       HRDATA,
  output logic [ADDR_W-1:0]       HADDR,
  output logic [2:0]              HBURST,
  output logic [2:0]              HSIZE,
  output logic [DATA_W-1:0]       HWDATA,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    wpush,
  output logic                    wfull,
  output logic [$clog2(WDEPTH):0] wcount,
  output logic [DATA_W-1:0]       rdata,
  input  logic                    rpop,
  output logic                    rempty,
  output logic [$clog2(RDEPTH):0] rcount,
  output logic                    wr_underrun,
  output logic                    rd_overflow,
  output logic                    err_1kb
);
  localparam int WAW = $clog2(WDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [WAW:0] WDEPTH_C = (WAW + 1)'(WDEPTH);
  localparam logic [RAW:0] RDEPTH_C = (RAW + 1)'(RDEPTH);

  logic              dp_valid_r;
  logic              dp_write_r;
  logic [DATA_W-1:0] wmem_r [WDEPTH];
  logic [DATA_W-1:0] rmem_r [RDEPTH];
  logic [WAW-1:0]    wwr_ptr_r, wrd_ptr_r;
  logic [RAW-1:0]    rwr_ptr_r, rrd_ptr_r;

  logic              idle_s, advance_s, wrap_s;
  logic [2:0]        eff_size_s;
  logic [ADDR_W-1:0] inc_s, mask_s, next_addr_s;
  logic              wempty_s, wpop_s, wpush_s, underrun_s;
  logic              rfull_s, rpush_req_s, rpush_s, rpop_s, overflow_s;

  // Address generator and FIFO handshake decode
  always_comb begin
    idle_s     = (HTRANS == HTRANS_IDLE) && !dp_valid_r;
    advance_s  = HREADY && HTRANS[1];
    eff_size_s = (HSIZE > MAX_SIZE) ? MAX_SIZE : HSIZE;
    inc_s      = ADDR_W'(1) << eff_size_s;
    case (HBURST)
      3'b010: begin
        wrap_s = 1'b1;
        mask_s = (ADDR_W'(4) << eff_size_s) - ADDR_W'(1);
      end
      3'b100: begin
        wrap_s = 1'b1;
        mask_s = (ADDR_W'(8) << eff_size_s) - ADDR_W'(1);
      end
      3'b110: begin
        wrap_s = 1'b1;
        mask_s = (ADDR_W'(16) << eff_size_s) - ADDR_W'(1);
      end
      default: begin
        wrap_s = 1'b0;
        mask_s = {ADDR_W{1'b0}};
      end
    endcase
    if (wrap_s) begin
      next_addr_s = (HADDR & ~mask_s) | ((HADDR + inc_s) & mask_s);
    end else begin
      next_addr_s = HADDR + inc_s;
    end

    wempty_s   = (wcount == {(WAW + 1){1'b0}});
    wfull      = (wcount == WDEPTH_C);
    underrun_s = HREADY && dp_valid_r && dp_write_r && wempty_s;
    wpop_s     = HREADY && dp_valid_r && dp_write_r && !wempty_s;
    wpush_s    = wpush && (!wfull || wpop_s);
    HWDATA     = wempty_s ? {DATA_W{1'b0}} : wmem_r[wrd_ptr_r];

    rempty      = (rcount == {(RAW + 1){1'b0}});
    rfull_s     = (rcount == RDEPTH_C);
    rpush_req_s = HREADY && dp_valid_r && !dp_write_r;
    rpop_s      = rpop && !rempty;
    // A full read FIFO still accepts the beat when the user pops on the same edge
    rpush_s     = rpush_req_s && (!rfull_s || rpop);
    overflow_s  = rpush_req_s && rfull_s && !rpop;
    rdata       = rempty ? {DATA_W{1'b0}} : rmem_r[rrd_ptr_r];
  end

  // Bus-side registers, tracker, FIFO pointers/counts and sticky flags
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR       <= {ADDR_W{1'b0}};
      HBURST      <= 3'b000;
      HSIZE       <= 3'b000;
      dp_valid_r  <= 1'b0;
      dp_write_r  <= 1'b0;
      wwr_ptr_r   <= {WAW{1'b0}};
      wrd_ptr_r   <= {WAW{1'b0}};
      wcount      <= {(WAW + 1){1'b0}};
      rwr_ptr_r   <= {RAW{1'b0}};
      rrd_ptr_r   <= {RAW{1'b0}};
      rcount      <= {(RAW + 1){1'b0}};
      wr_underrun <= 1'b0;
      rd_overflow <= 1'b0;
    end else begin
      if (load && idle_s) begin
        HADDR       <= start_addr;
        HBURST      <= burst;
        HSIZE       <= size;
        wr_underrun <= 1'b0;
        rd_overflow <= 1'b0;
      end else begin
        if (advance_s) begin
          HADDR <= next_addr_s;
        end
        wr_underrun <= wr_underrun | underrun_s;
        rd_overflow <= rd_overflow | overflow_s;
      end
      if (HREADY) begin
        dp_valid_r <= HTRANS[1];
        dp_write_r <= HWRITE;
      end
      if (wpush_s) wwr_ptr_r <= wwr_ptr_r + WAW'(1);
      if (wpop_s)  wrd_ptr_r <= wrd_ptr_r + WAW'(1);
      wcount <= wcount + (WAW + 1)'(wpush_s) - (WAW + 1)'(wpop_s);
      if (rpush_s) rwr_ptr_r <= rwr_ptr_r + RAW'(1);
      if (rpop_s)  rrd_ptr_r <= rrd_ptr_r + RAW'(1);
      rcount <= rcount + (RAW + 1)'(rpush_s) - (RAW + 1)'(rpop_s);
    end
  end

  // FIFO storage; contents are don't-care until counted valid
  always_ff @(posedge HCLK) begin
    if (wpush_s) wmem_r[wwr_ptr_r] <= wdata;
    if (rpush_s) rmem_r[rwr_ptr_r] <= HRDATA;
  end

`ifdef AHB_DP_BOUNDARY_CHECK_EN
  logic cross_1kb_s;

  // Flags any incrementing advance that leaves the current 1 KB page
  always_comb begin
    cross_1kb_s = advance_s && !wrap_s && (next_addr_s[ADDR_W-1:10] != HADDR[ADDR_W-1:10]);
  end

  // Sticky boundary error, cleared by an accepted load
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_1kb <= 1'b0;
    end else if (load && idle_s) begin
      err_1kb <= 1'b0;
    end else begin
      err_1kb <= err_1kb | cross_1kb_s;
    end
  end
`else
  assign err_1kb = 1'b0;
`endif

endmodule

// File: doc/ahb_master_datapath.md
# ahb_master_datapath

Address, write-data and read-data datapath for the AHB-Lite master; sits directly beside the master control FSM, which drives HTRANS/HWRITE while this block drives HADDR/HBURST/HSIZE/HWDATA and captures HRDATA. It generates burst addresses for INCR and WRAP bursts. It buffers outgoing write words in a write FIFO and incoming read words in a read FIFO. Its user side faces the SPI bridge logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, bus data width (32 or 64)
- WDEPTH, 8, write FIFO depth (power of 2)
- RDEPTH, 8, read FIFO depth (power of 2)

- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- load  in  1  latch start_addr/burst/size for a new transfer
- start_addr  in  ADDR_W  first beat address
- burst  in  3  AHB HBURST encoding
- size  in  3  AHB HSIZE encoding
- HTRANS  in  2  transfer type from the control FSM
- HWRITE  in  1  direction from the control FSM
- HREADY  in  1  bus ready
- HRDATA  in  DATA_W  slave read data
- HADDR  out  ADDR_W  bus address
- HBURST  out  3  latched burst
- HSIZE  out  3  latched size
- HWDATA  out  DATA_W  write FIFO head; 0 when empty
- wdata / wpush  in  DATA_W / 1  write FIFO push
- wfull  out  1, wcount  out  $clog2(WDEPTH)+1
- rdata  out  DATA_W  read FIFO head; 0 when empty
- rpop  in  1  read FIFO pop
- rempty  out  1, rcount  out  $clog2(RDEPTH)+1
- wr_underrun  out  1  sticky: write data phase with empty write FIFO
- rd_overflow  out  1  sticky: read beat dropped, read FIFO full
- err_1kb  out  1  sticky: INCR address crossed a 1 KB boundary

## Operation
- Reset: HADDR=0, HBURST=0, HSIZE=0, HWDATA=0, rdata=0, wcount=rcount=0, wfull=0, rempty=1, all flags 0, data-phase tracker cleared.
- Idle means HTRANS==IDLE and no pending data phase.
- load when idle: HADDR<=start_addr, HBURST<=burst, HSIZE<=size, all sticky flags cleared. The FIFOs are not flushed. load when not idle is ignored.
- Address advance at an edge with HREADY=1 and HTRANS[1]=1:
  - inc = 1<<HSIZE, with HSIZE clamped to log2(DATA_W/8).
  - WRAP4/8/16 (010/100/110): mask = beats*inc-1, next = (HADDR & ~mask) | ((HADDR+inc) & mask).
  - All other encodings: next = HADDR+inc, modulo 2^ADDR_W.
- Data-phase tracker: at each edge with HREADY=1, dp_valid<=HTRANS[1] and dp_write<=HWRITE. It holds while HREADY=0.
- Write pop: at an edge with HREADY && dp_valid && dp_write.
  - If the FIFO is empty: set wr_underrun and pop nothing.
- Read push: at an edge with HREADY && dp_valid && !dp_write, HRDATA is pushed.
  - If the FIFO is full and rpop is not asserted: the word is dropped and rd_overflow is set.
- FIFO rules:
  - Write FIFO: push when full is ignored; push+pop when full is accepted.
  - Read FIFO: rpop when empty is ignored.
  - No bypass: a word pushed into an empty FIFO becomes visible the next cycle.

## Timing
- HADDR is registered and changes only on advance or load. First beat: HADDR=start_addr while HTRANS=NONSEQ.
- HWDATA is combinational from the FIFO head and stable across wait states. It changes only after a pop edge.
- Read data is visible on rdata one cycle after its capture edge (when the FIFO was empty).
- Wait states (HREADY=0) freeze HADDR, the tracker, and all bus-side pops and pushes.
- Reset asserted mid-burst clears everything immediately. FIFO contents are lost.

## Configuration
- AHB_DP_BOUNDARY_CHECK_EN defined:
  - err_1kb is set when a non-WRAP advance changes HADDR[ADDR_W-1:10].
  - err_1kb is cleared by load.
- AHB_DP_BOUNDARY_CHECK_EN undefined: err_1kb is tied to 0 and no compare logic is generated.

## Test plan
- load 0x100, INCR4, size word, 4 words pushed, 4 NONSEQ/SEQ beats with HREADY=1 -> HADDR 0x100,0x104,0x108,0x10C; HWDATA shows words in order; wcount ends at 0.
- load 0x38, WRAP4, word -> HADDR 0x38,0x3C,0x30,0x34. WRAP8 halfword from 0x0E -> 0x0E,0x00,0x02,…,0x0C.
- INCR4 read with HREADY low for 2 cycles in the beat-2 data phase -> HADDR held; exactly 4 words in the read FIFO, no duplicates; rcount=4.
- Write beat with an empty write FIFO -> wr_underrun=1, HWDATA=0. A following load clears it.
- RDEPTH=8 full, then a read beat with rpop=0 -> word dropped, rd_overflow=1. Same beat with rpop=1 -> accepted, rcount stays 8.
- INCR from 0x3FC, word, macro defined -> second HADDR=0x400 and err_1kb=1. Macro undefined -> err_1kb stays 0.
